// File: rtl/unary_stream_decoder.sv
// Counts ones over fixed INPUT_WIDTH-bit unary frames, hands the count out through
// a valid/ready port and publishes running lower/upper bounds while a frame arrives.
module unary_stream_decoder #(
    parameter int INPUT_WIDTH = 32,
    parameter int COUNT_WIDTH = $clog2(INPUT_WIDTH + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   a,
    input  logic                   a_valid,
    output logic                   ready,
    input  logic                   flush,
    output logic [COUNT_WIDTH-1:0] result,
    output logic                   result_valid,
    input  logic                   result_ready,
    output logic [COUNT_WIDTH-1:0] lower,
    output logic [COUNT_WIDTH-1:0] upper,
    output logic [COUNT_WIDTH-1:0] bits_seen
);

    localparam logic [COUNT_WIDTH-1:0] FRAME_LEN = COUNT_WIDTH'(INPUT_WIDTH);
    localparam logic [COUNT_WIDTH-1:0] LAST_BIT  = COUNT_WIDTH'(INPUT_WIDTH - 1);

    typedef enum logic {
        COLLECT,
        DONE
    } state_t;

    state_t                 state_reg;
    logic [COUNT_WIDTH-1:0] ones_reg;
    logic [COUNT_WIDTH-1:0] bits_seen_reg;
    logic [COUNT_WIDTH-1:0] result_reg;
    logic [COUNT_WIDTH-1:0] lower_reg;
    logic [COUNT_WIDTH-1:0] upper_reg;
    logic                   result_valid_reg;

    logic                   beat;
    logic [COUNT_WIDTH-1:0] ones_next;
    logic [COUNT_WIDTH-1:0] bits_seen_next;
    logic [COUNT_WIDTH-1:0] remaining_next;

    // ready depends only on registered state and the abort inputs, never on a_valid.
    assign ready          = (state_reg == COLLECT) & ~reset & ~flush;
    assign beat           = a_valid & ready;
    assign ones_next      = ones_reg + {{(COUNT_WIDTH-1){1'b0}}, a};
    assign bits_seen_next = bits_seen_reg + 1'b1;
    assign remaining_next = FRAME_LEN - bits_seen_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= COLLECT;
            ones_reg         <= '0;
            bits_seen_reg    <= '0;
            result_reg       <= '0;
            result_valid_reg <= 1'b0;
            lower_reg        <= '0;
            upper_reg        <= FRAME_LEN;
        end else if (flush) begin
            // Abort drops any held result but leaves the result register alone.
            state_reg        <= COLLECT;
            ones_reg         <= '0;
            bits_seen_reg    <= '0;
            result_valid_reg <= 1'b0;
            lower_reg        <= '0;
            upper_reg        <= FRAME_LEN;
        end else begin
            case (state_reg)
                COLLECT: begin
                    if (beat) begin
                        if (bits_seen_reg == LAST_BIT) begin
                            result_reg       <= ones_next;
                            result_valid_reg <= 1'b1;
                            ones_reg         <= '0;
                            bits_seen_reg    <= '0;
                            lower_reg        <= ones_next;
                            upper_reg        <= ones_next;
                            state_reg        <= DONE;
                        end else begin
                            ones_reg      <= ones_next;
                            bits_seen_reg <= bits_seen_next;
                            lower_reg     <= ones_next;
                            upper_reg     <= ones_next + remaining_next;
                        end
                    end
                end
                DONE: begin
                    if (result_valid_reg && result_ready) begin
                        result_valid_reg <= 1'b0;
                        lower_reg        <= '0;
                        upper_reg        <= FRAME_LEN;
                        state_reg        <= COLLECT;
                    end
                end
                default: state_reg <= COLLECT;
            endcase
        end
    end

    assign result       = result_reg;
    assign result_valid = result_valid_reg;
    assign lower        = lower_reg;
    assign upper        = upper_reg;
    assign bits_seen    = bits_seen_reg;

endmodule

// File: tb/tb_unary_stream_decoder.sv
// Bench for unary_stream_decoder: fixed vector table, directed corner sequences and
// random traffic, all checked against a queue-based frame model.
module tb_unary_stream_decoder;

    localparam int W  = 8;
    localparam int CW = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          a = 1'b0;
    logic          a_valid = 1'b0;
    logic          ready;
    logic          flush = 1'b0;
    logic [CW-1:0] result;
    logic          result_valid;
    logic          result_ready = 1'b0;
    logic [CW-1:0] lower;
    logic [CW-1:0] upper;
    logic [CW-1:0] bits_seen;

    unary_stream_decoder #(.INPUT_WIDTH(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .a            (a),
        .a_valid      (a_valid),
        .ready        (ready),
        .flush        (flush),
        .result       (result),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .lower        (lower),
        .upper        (upper),
        .bits_seen    (bits_seen)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: the bits of the current frame kept as a queue.
    int m_q[$];
    bit m_done   = 1'b0;
    bit m_rv     = 1'b0;
    int m_result = 0;
    bit m_ready;
    logic obs_ready;

    function automatic int m_sum();
        int s = 0;
        foreach (m_q[i]) s += m_q[i];
        return s;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        total++;
        if (act !== 32'(exp)) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, sample ready before the edge, then outputs after it.
    task automatic apply(input bit r, input bit f, input bit v, input bit b, input bit rr);
        reset = r; flush = f; a_valid = v; a = b; result_ready = rr;
        #1;
        obs_ready = ready;
        m_ready = !m_done && !r && !f;
        chk("ready", {31'b0, obs_ready}, int'(m_ready));
        @(posedge clk);
        if (r) begin
            m_q.delete(); m_done = 0; m_rv = 0; m_result = 0;
        end else if (f) begin
            m_q.delete(); m_done = 0; m_rv = 0;
        end else if (m_done) begin
            if (rr) begin m_done = 0; m_rv = 0; end
        end else if (v && m_ready) begin
            m_q.push_back(int'(b));
            if (m_q.size() == W) begin
                m_result = m_sum(); m_rv = 1; m_done = 1; m_q.delete();
            end
        end
        #1;
        chk("result", 32'(result), m_result);
        chk("result_valid", {31'b0, result_valid}, int'(m_rv));
        chk("lower", 32'(lower), m_done ? m_result : m_sum());
        chk("upper", 32'(upper), m_done ? m_result : m_sum() + W - m_q.size());
        chk("bits_seen", 32'(bits_seen), m_q.size());
    endtask

    typedef struct {
        bit r, f, v, b, rr;
        int rdy, res, rv, lo, up, bits;
    } vec_t;

    vec_t tbl[12];
    int   results[$];
    int   bubbles;
    int   zi;
    bit   frame_pat[8] = '{1, 1, 1, 1, 1, 0, 0, 0};

    initial begin
        // Mixed frame 1,0,1,1,0,0,1,0 with a two-cycle a_valid gap after beat 3.
        tbl[0]  = '{0,0,1,1,1, 1, 0,0,1,8,1};
        tbl[1]  = '{0,0,1,0,1, 1, 0,0,1,7,2};
        tbl[2]  = '{0,0,1,1,1, 1, 0,0,2,7,3};
        tbl[3]  = '{0,0,0,1,1, 1, 0,0,2,7,3};
        tbl[4]  = '{0,0,0,0,1, 1, 0,0,2,7,3};
        tbl[5]  = '{0,0,1,1,1, 1, 0,0,3,7,4};
        tbl[6]  = '{0,0,1,0,1, 1, 0,0,3,6,5};
        tbl[7]  = '{0,0,1,0,1, 1, 0,0,3,5,6};
        tbl[8]  = '{0,0,1,1,1, 1, 0,0,4,5,7};
        tbl[9]  = '{0,0,1,0,1, 1, 4,1,4,4,0};
        tbl[10] = '{0,0,1,1,1, 0, 4,0,0,8,0};
        tbl[11] = '{0,0,0,0,1, 1, 4,0,0,8,0};

        // Reset values.
        apply(1, 0, 0, 0, 0);
        apply(1, 0, 1, 1, 1);
        chk("rst_ready_low", {31'b0, obs_ready}, 0);
        chk("rst_result", 32'(result), 0);
        chk("rst_upper", 32'(upper), W);

        // Table-driven mixed frame.
        foreach (tbl[i]) begin
            apply(tbl[i].r, tbl[i].f, tbl[i].v, tbl[i].b, tbl[i].rr);
            chk($sformatf("tbl%0d_ready", i), {31'b0, obs_ready}, tbl[i].rdy);
            chk($sformatf("tbl%0d_result", i), 32'(result), tbl[i].res);
            chk($sformatf("tbl%0d_rv", i), {31'b0, result_valid}, tbl[i].rv);
            chk($sformatf("tbl%0d_lower", i), 32'(lower), tbl[i].lo);
            chk($sformatf("tbl%0d_upper", i), 32'(upper), tbl[i].up);
            chk($sformatf("tbl%0d_bits", i), 32'(bits_seen), tbl[i].bits);
        end

        // All-ones frame: upper pinned at 8, one-cycle bubble.
        apply(1, 0, 0, 0, 1);
        for (int i = 0; i < W; i++) begin
            apply(0, 0, 1, 1, 1);
            chk("ones_upper", 32'(upper), W);
        end
        chk("ones_result", 32'(result), 8);
        chk("ones_rv", {31'b0, result_valid}, 1);
        apply(0, 0, 0, 0, 1);
        chk("ones_bubble", {31'b0, obs_ready}, 0);
        apply(0, 0, 0, 0, 1);
        chk("ones_ready_again", {31'b0, obs_ready}, 1);

        // Back-pressure on a result of 5.
        apply(1, 0, 0, 0, 0);
        for (int i = 0; i < W; i++) apply(0, 0, 1, frame_pat[i], 0);
        for (int i = 0; i < 6; i++) begin
            apply(0, 0, 1, 1, 0);
            chk("bp_ready", {31'b0, obs_ready}, 0);
            chk("bp_rv", {31'b0, result_valid}, 1);
            chk("bp_result", 32'(result), 5);
        end
        apply(0, 0, 0, 0, 1);
        apply(0, 0, 0, 0, 0);
        chk("bp_ready_after", {31'b0, obs_ready}, 1);

        // Flush after 5 beats carrying 3 ones, then a frame of zeros.
        apply(1, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) apply(0, 0, 1, frame_pat[i + 2], 1);
        chk("fl_lower_pre", 32'(lower), 3);
        apply(0, 1, 1, 1, 1);
        chk("fl_ready", {31'b0, obs_ready}, 0);
        chk("fl_lower", 32'(lower), 0);
        chk("fl_upper", 32'(upper), 8);
        chk("fl_rv", {31'b0, result_valid}, 0);
        for (int i = 0; i < W; i++) apply(0, 0, 1, 0, 1);
        chk("fl_next_result", 32'(result), 0);
        chk("fl_next_rv", {31'b0, result_valid}, 1);

        // Reset while holding a result of 6.
        apply(1, 0, 0, 0, 0);
        for (int i = 0; i < W; i++) apply(0, 0, 1, (i < 6) ? 1'b1 : 1'b0, 0);
        chk("rd_result_pre", 32'(result), 6);
        apply(1, 0, 0, 0, 0);
        chk("rd_result", 32'(result), 0);
        chk("rd_rv", {31'b0, result_valid}, 0);
        chk("rd_upper", 32'(upper), 8);
        chk("rd_bits", 32'(bits_seen), 0);
        apply(0, 0, 0, 0, 0);
        chk("rd_ready", {31'b0, obs_ready}, 1);

        // Back-to-back frames: 8 ones then 8 zeros, a_valid held high throughout.
        apply(1, 0, 0, 0, 1);
        results.delete();
        bubbles = 0;
        zi = 0;
        for (int c = 0; c < 40 && zi < 2 * W; c++) begin
            apply(0, 0, 1, (zi < W) ? 1'b1 : 1'b0, 1);
            if (obs_ready) zi++;
            else if (zi == W) bubbles++;
            if (result_valid) results.push_back(int'(result));
        end
        apply(0, 0, 0, 0, 1);
        chk("b2b_count", 32'(results.size()), 2);
        if (results.size() == 2) begin
            chk("b2b_first", 32'(results[0]), 8);
            chk("b2b_second", 32'(results[1]), 0);
        end
        chk("b2b_bubbles", 32'(bubbles), 1);

        // Random traffic against the model.
        for (int c = 0; c < 2000; c++) begin
            apply(($urandom_range(63) == 0), ($urandom_range(31) == 0),
                  ($urandom_range(3) != 0), 1'($urandom), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/unary_stream_decoder.md
# unary_stream_decoder

Downstream consumer for the unary arithmetic units (e.g. the multiply-by-two stage). Accepts a serial unary bitstream one bit per `a_valid` beat and counts ones over a fixed frame of `INPUT_WIDTH` bits. Presents the binary ones-count through a valid/ready output handshake. While the frame is arriving, it also publishes running lower/upper bounds on the final count, for early-decision logic.

## Interface
Parameters:
- `INPUT_WIDTH`, 32: bits per unary frame; must be ≥ 2.
- `COUNT_WIDTH`, `$clog2(INPUT_WIDTH + 1)`: width of all count/bound outputs; must represent 0..`INPUT_WIDTH` inclusive.

Ports:
- `clk`  in  1: sole clock, all state updates on rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `a`  in  1: unary stream bit, sampled only on an accepted beat.
- `a_valid`  in  1: upstream `valid`; `a` is meaningful this cycle.
- `ready`  out  1: decoder accepts a beat this cycle (beat accepted = `a_valid & ready`).
- `flush`  in  1: synchronous abort of the current frame, no result produced.
- `result`  out  `COUNT_WIDTH`: ones-count of the completed frame.
- `result_valid`  out  1: `result` is held and valid.
- `result_ready`  in  1: downstream consumes `result` when high with `result_valid`.
- `lower`  out  `COUNT_WIDTH`: ones seen so far in the current frame.
- `upper`  out  `COUNT_WIDTH`: `lower` + bits still to come in the frame.
- `bits_seen`  out  `COUNT_WIDTH`: beats accepted in the current frame.

## Operation
- States: COLLECT, DONE. Reset state COLLECT.
- `ready` = (state == COLLECT) & !reset & !flush. It is combinational from registered state, with no dependence on `a_valid`.
- **COLLECT, on an accepted beat:**
  - `ones += a`; `bits_seen += 1`.
  - If this beat is bit `INPUT_WIDTH`-1, i.e. `bits_seen == INPUT_WIDTH-1` before the update:
    - load `result = ones + a`;
    - set `result_valid = 1`;
    - clear `bits_seen` and `ones` to 0;
    - go to DONE.
- **COLLECT, no accepted beat:** hold all state.
- **DONE:** `ready = 0`; `result` and `result_valid` are held stable. When `result_valid & result_ready`:
  - `result_valid` goes to 0;
  - return to COLLECT;
  - `result` keeps its last value (don't-care for consumers).
- **Bounds:**
  - In COLLECT: `lower` = `ones`; `upper` = `ones + (INPUT_WIDTH - bits_seen)`. Both are registered and update in the same edge as the counters.
  - In DONE: `lower` = `upper` = `result`.
- **Arithmetic:** every count is unsigned `COUNT_WIDTH`. `upper` never exceeds `INPUT_WIDTH` by construction, so no saturation logic is required. The sum `ones + a` cannot overflow, since at most `INPUT_WIDTH` ones exist.
- **`flush` (in any state):**
  - next cycle is COLLECT;
  - `ones` = `bits_seen` = 0, so `lower` = 0 and `upper` = `INPUT_WIDTH`;
  - `result_valid` = 0, dropping any unconsumed result;
  - a beat presented in the flush cycle is not accepted (`ready` = 0).
- **`reset`:** same effect as `flush`, plus `result` = 0. It has priority over `flush` and over all handshakes, and may occur mid-frame or in DONE.

## Timing
- Reset values of the outputs:
  - `ready` = 0 while `reset` is high, then 1 in the first cycle after deassertion;
  - `result` = 0;
  - `result_valid` = 0;
  - `lower` = 0;
  - `upper` = `INPUT_WIDTH`;
  - `bits_seen` = 0.
- Throughput: one bit per cycle in COLLECT.
- Latency: `result_valid` rises on the edge that accepts the final bit, so it is visible in the cycle after that beat.
- Inter-frame bubble: at least one cycle with `ready` = 0 (the DONE cycle), even when `result_ready` is held high. There is no bypass of DONE.
- Consumption in DONE with `result_ready` high: `ready` = 1 in the very next cycle.
- Back-pressure: `result_ready` low holds DONE indefinitely. Upstream sees `ready` = 0, and its bitstream must stall while `a_valid` is held.
- `a_valid` low mid-frame: the frame stretches and the bounds hold.
- Bounds are monotone within a frame: `lower` is non-decreasing, `upper` is non-increasing, and `upper - lower = INPUT_WIDTH - bits_seen`.

## Test plan
- **All-ones frame:** `INPUT_WIDTH`=8, reset, then 8 consecutive beats of `a`=1 with `result_ready`=1.
  - Required: `result`=8 and `result_valid` pulse one cycle after beat 8.
  - Required: `ready`=0 for exactly 1 cycle.
  - Required: `upper` stays at 8 throughout the frame.
- **Mixed frame with gaps:** pattern 1,0,1,1,0,0,1,0 with `a_valid` dropped for 2 cycles after beat 3.
  - Required: `result`=4.
  - Required after beat 3: `lower`=2, `upper`=7, `bits_seen`=3, held through the gap.
- **Back-pressure:** complete a frame of `result`=5 with `result_ready`=0 for 6 cycles.
  - Required: `result_valid`=1, `result`=5 and `ready`=0 stable for all 6 cycles.
  - Required: `ready`=1 in the cycle after `result_ready` rises.
- **Flush mid-frame:** after 5 beats (3 ones), assert `flush` for 1 cycle, then feed 8 zeros.
  - Required: no `result_valid` for the aborted frame.
  - Required: `lower`=0, `upper`=8 after the flush.
  - Required: the next frame gives `result`=0.
- **Reset in DONE:** assert `reset` while `result_valid`=1 and `result`=6.
  - Required next cycle: `result`=0, `result_valid`=0, `upper`=8, `bits_seen`=0.
  - Required: `ready`=1 after deassertion.
- **Back-to-back frames:** two frames of 8 ones, then 8 zeros, with `result_ready`=1.
  - Required: results 8 then 0.
  - Required: exactly one bubble cycle between the frames.
  - Required: no beat lost or double-counted.
